// File: rtl/eth_pkg.sv
// Shared constants, record geometry and FSM encoding for the UDP command writer.
package eth_pkg;

  localparam logic [7:0] MAGIC  = 8'hA5;
  localparam int         REC_W  = 40;
  localparam int         REC_AW = 4;
  localparam int         IDX_W  = 5;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CNT    = 4'd1,
    ADDR   = 4'd2,
    D0     = 4'd3,
    D1     = 4'd4,
    D2     = 4'd5,
    D3     = 4'd6,
    COMMIT = 4'd7,
    DROP   = 4'd8
  } eth_state_e;

  // Up to two errors can land in one cycle: an abandoned packet plus a bad new start.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/cmd_rec_buf.sv
// Record buffer: one write port, a registered read port and a synchronous clear.
module cmd_rec_buf
  import eth_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [REC_AW-1:0] wr_addr,
  input  logic [REC_W-1:0]  wr_data,
  input  logic [REC_AW-1:0] rd_addr,
  output logic [REC_W-1:0]  rd_data
);

  logic [REC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en && (int'(wr_addr) < DEPTH)) mem[wr_addr] <= wr_data;
      rd_data <= (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/eth_cmd_writer.sv
// Parses A5/N/records UDP payloads into register-bus writes.
// Define ETH_CMD_ATOMIC_EN to buffer records and commit only after a clean eop.
module eth_cmd_writer
  import eth_pkg::*;
#(
  parameter int MAX_REC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_sop,
  input  logic        i_rx_eop,
  output logic [7:0]  o_eb_addr,
  output logic [31:0] o_eb_wr_data,
  output logic        o_eb_wr,
  output logic        o_busy,
  output logic [15:0] o_wr_cnt,
  output logic [7:0]  o_err_cnt,
  output logic [3:0]  dbg_state
);

  // Receive stream: a byte transfers on every cycle i_rx_valid is high; there is
  // no back-pressure, and sop/eop mean nothing unless valid is also high.
  eth_state_e        state, state_n;
  logic [IDX_W-1:0]  rec_n, rec_idx;
  logic [7:0]        addr_q;
  logic [23:0]       data_q;
  logic [1:0]        err_inc;
  logic              take, rec_done, cnt_bad, is_last;
  logic [REC_W-1:0]  cur_rec;

  assign take     = i_rx_valid && !i_rx_sop;
  assign cnt_bad  = (i_rx_data == 8'd0) || (i_rx_data > 8'(MAX_REC));
  assign is_last  = (rec_idx == rec_n - IDX_W'(1));
  assign cur_rec  = {addr_q, data_q, i_rx_data};
  assign o_busy   = (state != IDLE);
  assign dbg_state = state;

`ifdef ETH_CMD_ATOMIC_EN
  logic [IDX_W-1:0]  commit_idx;
  logic              drop_pending, drop_n, pkt_ok, start;
  logic [REC_AW-1:0] rd_addr;
  logic [REC_W-1:0]  rd_data;

  assign start = i_rx_valid && i_rx_sop && (state != COMMIT) &&
                 (i_rx_data == MAGIC) && !i_rx_eop;

  // Record 0 is prefetched while idle so the first write can go out the cycle after eop.
  assign rd_addr = (state == COMMIT) ? REC_AW'(commit_idx + IDX_W'(1)) :
                   (pkt_ok ? REC_AW'(1) : '0);

  cmd_rec_buf #(.DEPTH(MAX_REC)) u_rec_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start),
    .wr_en   (rec_done),
    .wr_addr (rec_idx[REC_AW-1:0]),
    .wr_data (cur_rec),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
`endif

  always_comb begin
    state_n  = state;
    err_inc  = 2'd0;
    rec_done = 1'b0;
`ifdef ETH_CMD_ATOMIC_EN
    pkt_ok   = 1'b0;
    drop_n   = drop_pending;
`endif
    if (i_rx_valid && i_rx_sop) begin
`ifdef ETH_CMD_ATOMIC_EN
      if (state == COMMIT) begin
        err_inc = 2'd1;
        drop_n  = !i_rx_eop;
      end else
`endif
      begin
        // A packet already in DROP was counted when it failed.
        if (state != IDLE && state != DROP) err_inc = 2'd1;
        if (i_rx_data == MAGIC && !i_rx_eop) begin
          state_n = CNT;
        end else begin
          err_inc = err_inc + 2'd1;
          state_n = i_rx_eop ? IDLE : DROP;
        end
      end
    end else if (take) begin
      case (state)
        CNT: begin
          if (cnt_bad || i_rx_eop) begin
            err_inc = 2'd1;
            state_n = i_rx_eop ? IDLE : DROP;
          end else begin
            state_n = ADDR;
          end
        end
        ADDR: if (i_rx_eop) begin err_inc = 2'd1; state_n = IDLE; end else state_n = D0;
        D0:   if (i_rx_eop) begin err_inc = 2'd1; state_n = IDLE; end else state_n = D1;
        D1:   if (i_rx_eop) begin err_inc = 2'd1; state_n = IDLE; end else state_n = D2;
        D2:   if (i_rx_eop) begin err_inc = 2'd1; state_n = IDLE; end else state_n = D3;
        D3: begin
          rec_done = 1'b1;
          if (is_last && i_rx_eop) begin
`ifdef ETH_CMD_ATOMIC_EN
            pkt_ok  = 1'b1;
            state_n = COMMIT;
`else
            state_n = IDLE;
`endif
          end else if (is_last || i_rx_eop) begin
            err_inc = 2'd1;
            state_n = i_rx_eop ? IDLE : DROP;
          end else begin
            state_n = ADDR;
          end
        end
`ifdef ETH_CMD_ATOMIC_EN
        COMMIT: if (i_rx_eop) drop_n = 1'b0;
`endif
        DROP: if (i_rx_eop) state_n = IDLE;
        default: ;
      endcase
    end
`ifdef ETH_CMD_ATOMIC_EN
    if (state == COMMIT && commit_idx == rec_n) begin
      state_n = drop_n ? DROP : IDLE;
      drop_n  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_eb_addr    <= '0;
      o_eb_wr_data <= '0;
      o_eb_wr      <= 1'b0;
      o_wr_cnt     <= '0;
      o_err_cnt    <= '0;
      rec_n        <= '0;
      rec_idx      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
`ifdef ETH_CMD_ATOMIC_EN
      commit_idx   <= '0;
      drop_pending <= 1'b0;
`endif
    end else begin
      o_eb_wr   <= 1'b0;
      o_err_cnt <= sat_add8(o_err_cnt, err_inc);
      if (take) begin
        case (state)
          CNT: begin
            rec_n   <= i_rx_data[IDX_W-1:0];
            rec_idx <= '0;
          end
          ADDR:    addr_q         <= i_rx_data;
          D0:      data_q[23:16]  <= i_rx_data;
          D1:      data_q[15:8]   <= i_rx_data;
          D2:      data_q[7:0]    <= i_rx_data;
          D3:      rec_idx        <= rec_idx + IDX_W'(1);
          default: ;
        endcase
      end
`ifdef ETH_CMD_ATOMIC_EN
      drop_pending <= drop_n;
      if (pkt_ok) begin
        o_eb_wr                     <= 1'b1;
        {o_eb_addr, o_eb_wr_data}   <= (rec_idx == '0) ? cur_rec : rd_data;
        o_wr_cnt                    <= o_wr_cnt + 16'd1;
        commit_idx                  <= IDX_W'(1);
      end else if (state == COMMIT && commit_idx != rec_n) begin
        o_eb_wr                     <= 1'b1;
        {o_eb_addr, o_eb_wr_data}   <= rd_data;
        o_wr_cnt                    <= o_wr_cnt + 16'd1;
        commit_idx                  <= commit_idx + IDX_W'(1);
      end
`else
      if (rec_done) begin
        o_eb_wr      <= 1'b1;
        o_eb_addr    <= cur_rec[39:32];
        o_eb_wr_data <= cur_rec[31:0];
        o_wr_cnt     <= o_wr_cnt + 16'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_eth_cmd_writer.sv
// Directed bench for eth_cmd_writer; expectations follow ETH_CMD_ATOMIC_EN when defined.
module tb_eth_cmd_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0;
  logic [7:0]  eb_addr;
  logic [31:0] eb_wr_data;
  logic        eb_wr, busy;
  logic [15:0] wr_cnt;
  logic [7:0]  err_cnt;
  logic [3:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  int pos_cnt = 0;
  int wr_exp = 0;

  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];
  int          exp_t[$];
  int          got_t[$];
  logic [7:0]  pkt[$];
  int          sent_t[$];

  eth_cmd_writer #(.MAX_REC(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_rx_sop     (rx_sop),
    .i_rx_eop     (rx_eop),
    .o_eb_addr    (eb_addr),
    .o_eb_wr_data (eb_wr_data),
    .o_eb_wr      (eb_wr),
    .o_busy       (busy),
    .o_wr_cnt     (wr_cnt),
    .o_err_cnt    (err_cnt),
    .dbg_state    (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  // Write monitor: every strobe seen at a falling edge with the edge count.
  always @(negedge clk) begin
    if (eb_wr === 1'b1) begin
      got_q.push_back({eb_addr, eb_wr_data});
      got_t.push_back(pos_cnt);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop);
    @(negedge clk);
    rx_data  = d;
    rx_valid = 1'b1;
    rx_sop   = sop;
    rx_eop   = eop;
    sent_t.push_back(pos_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_sop   = 1'b0;
      rx_eop   = 1'b0;
    end
  endtask

  task automatic idle_to(input int t);
    while (pos_cnt < t) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_sop   = 1'b0;
      rx_eop   = 1'b0;
    end
  endtask

  task automatic new_pkt(input logic [7:0] n);
    pkt.delete();
    pkt.push_back(8'hA5);
    pkt.push_back(n);
  endtask

  task automatic add_rec(input logic [7:0] a, input logic [31:0] d);
    pkt.push_back(a);
    pkt.push_back(d[31:24]);
    pkt.push_back(d[23:16]);
    pkt.push_back(d[15:8]);
    pkt.push_back(d[7:0]);
  endtask

  task automatic send_pkt(input logic with_eop);
    sent_t.delete();
    for (int i = 0; i < pkt.size(); i++)
      send_byte(pkt[i], (i == 0), with_eop && (i == pkt.size() - 1));
  endtask

  // Streaming: strobe one cycle after the record's D3 byte.
  // Atomic: strobes on consecutive cycles starting one cycle after eop.
  task automatic expect_rec(input int i, input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
`ifdef ETH_CMD_ATOMIC_EN
    exp_t.push_back(sent_t[sent_t.size() - 1] + 1 + i);
`else
    exp_t.push_back(sent_t[6 + 5 * i] + 1);
`endif
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_num_writes"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_rec%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      chk($sformatf("%s_time%0d", tag, i), 64'(got_t[i]), 64'(exp_t[i]));
    end
    exp_q.delete();
    exp_t.delete();
    got_q.delete();
    got_t.delete();
  endtask

  initial begin
    int t;
    int last_t;

    // Reset state
    rst_n = 1'b0;
    idle(3);
    chk("rst_addr",    64'(eb_addr),    64'h0);
    chk("rst_data",    64'(eb_wr_data), 64'h0);
    chk("rst_wr",      64'(eb_wr),      64'h0);
    chk("rst_busy",    64'(busy),       64'h0);
    chk("rst_wr_cnt",  64'(wr_cnt),     64'h0);
    chk("rst_err_cnt", 64'(err_cnt),    64'h0);
    rst_n = 1'b1;
    idle(2);

    // A5 01 03 11 22 33 44
    new_pkt(8'h01);
    add_rec(8'h03, 32'h11223344);
    send_pkt(1'b1);
    t = sent_t[sent_t.size() - 1];
    expect_rec(0, 8'h03, 32'h11223344);
    idle(1);
    chk("single_strobe",      64'(eb_wr),  64'h1);
    chk("single_cnt_with_wr", 64'(wr_cnt), 64'h1);
    idle(1);
    chk("single_strobe_1cyc", 64'(eb_wr),      64'h0);
    chk("single_addr_held",   64'(eb_addr),    64'h03);
    chk("single_data_held",   64'(eb_wr_data), 64'h11223344);
    idle(2);
    check_writes("single");
    wr_exp = 1;
    chk("single_busy", 64'(busy),    64'h0);
    chk("single_err",  64'(err_cnt), 64'h0);

    // Three records in order
    new_pkt(8'h03);
    add_rec(8'h10, 32'hAABBCCDD);
    add_rec(8'h20, 32'h01020304);
    add_rec(8'h30, 32'hDEADBEEF);
    send_pkt(1'b1);
    t = sent_t[sent_t.size() - 1];
    expect_rec(0, 8'h10, 32'hAABBCCDD);
    expect_rec(1, 8'h20, 32'h01020304);
    expect_rec(2, 8'h30, 32'hDEADBEEF);
`ifdef ETH_CMD_ATOMIC_EN
    last_t = t + 3;
`else
    last_t = t + 1;
`endif
    idle_to(last_t);
    chk("n3_last_strobe", 64'(eb_wr), 64'h1);
    idle(1);
    chk("n3_busy_after", 64'(busy),  64'h0);
    chk("n3_wr_after",   64'(eb_wr), 64'h0);
    idle(2);
    check_writes("n3");
    wr_exp += 3;
    chk("n3_wr_cnt", 64'(wr_cnt), 64'(wr_exp));

    // Bad magic, N=0, N=17, then a good packet
    pkt.delete();
    pkt.push_back(8'h5A);
    pkt.push_back(8'h01);
    add_rec(8'h03, 32'h11223344);
    send_pkt(1'b1);
    idle(2);
    chk("bad_magic_err", 64'(err_cnt), 64'h1);
    new_pkt(8'h00);
    send_pkt(1'b1);
    idle(2);
    chk("n0_err", 64'(err_cnt), 64'h2);
    new_pkt(8'h11);
    add_rec(8'h01, 32'h00000000);
    send_pkt(1'b1);
    idle(2);
    chk("n17_err", 64'(err_cnt), 64'h3);
    new_pkt(8'h01);
    add_rec(8'h07, 32'hCAFEF00D);
    send_pkt(1'b1);
    expect_rec(0, 8'h07, 32'hCAFEF00D);
    idle(3);
    check_writes("after_bad");
    wr_exp += 1;
    chk("after_bad_wr_cnt", 64'(wr_cnt), 64'(wr_exp));

    // N=2 truncated by eop on record 1's last byte
    new_pkt(8'h02);
    add_rec(8'h40, 32'h11111111);
    send_pkt(1'b1);
`ifndef ETH_CMD_ATOMIC_EN
    expect_rec(0, 8'h40, 32'h11111111);
    wr_exp += 1;
`endif
    idle(3);
    check_writes("trunc");
    chk("trunc_err",    64'(err_cnt), 64'h4);
    chk("trunc_wr_cnt", 64'(wr_cnt),  64'(wr_exp));

    // sop mid-record abandons the packet; new one runs normally
    new_pkt(8'h02);
    pkt.push_back(8'h50);
    pkt.push_back(8'h12);
    pkt.push_back(8'h34);
    send_pkt(1'b0);
    new_pkt(8'h01);
    add_rec(8'h60, 32'h89ABCDEF);
    send_pkt(1'b1);
    expect_rec(0, 8'h60, 32'h89ABCDEF);
    idle(3);
    check_writes("midsop");
    wr_exp += 1;
    chk("midsop_err",    64'(err_cnt), 64'h5);
    chk("midsop_wr_cnt", 64'(wr_cnt),  64'(wr_exp));

    // Valid bytes without sop in IDLE are ignored
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b1);
    idle(2);
    chk("nosop_busy", 64'(busy),    64'h0);
    chk("nosop_err",  64'(err_cnt), 64'h5);

    // 256 bad packets saturate the error counter
    for (int i = 0; i < 256; i++) send_byte(8'h5A, 1'b1, 1'b1);
    idle(2);
    chk("err_saturate", 64'(err_cnt), 64'hFF);
    check_writes("saturate");
    chk("saturate_wr_cnt", 64'(wr_cnt), 64'(wr_exp));

    // Reset after two writes of an N=4 packet
    new_pkt(8'h04);
    add_rec(8'hA1, 32'h10000001);
    add_rec(8'hA2, 32'h20000002);
    add_rec(8'hA3, 32'h30000003);
    add_rec(8'hA4, 32'h40000004);
`ifdef ETH_CMD_ATOMIC_EN
    send_pkt(1'b1);
    t = sent_t[sent_t.size() - 1];
    expect_rec(0, 8'hA1, 32'h10000001);
    expect_rec(1, 8'hA2, 32'h20000002);
    idle_to(t + 2);
`else
    sent_t.delete();
    for (int i = 0; i < 14; i++) send_byte(pkt[i], (i == 0), 1'b0);
    expect_rec(0, 8'hA1, 32'h10000001);
    expect_rec(1, 8'hA2, 32'h20000002);
    idle(1);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_addr",    64'(eb_addr),    64'h0);
    chk("midrst_data",    64'(eb_wr_data), 64'h0);
    chk("midrst_wr",      64'(eb_wr),      64'h0);
    chk("midrst_busy",    64'(busy),       64'h0);
    chk("midrst_wr_cnt",  64'(wr_cnt),     64'h0);
    chk("midrst_err_cnt", 64'(err_cnt),    64'h0);
    idle(2);
    rst_n = 1'b1;
`ifndef ETH_CMD_ATOMIC_EN
    for (int i = 14; i < pkt.size(); i++) send_byte(pkt[i], 1'b0, (i == pkt.size() - 1));
`endif
    idle(6);
    check_writes("midrst");
    chk("midrst_after_wr_cnt",  64'(wr_cnt),  64'h0);
    chk("midrst_after_err_cnt", 64'(err_cnt), 64'h0);

    // Next packet after reset is accepted
    new_pkt(8'h01);
    add_rec(8'h7E, 32'h0BADF00D);
    send_pkt(1'b1);
    expect_rec(0, 8'h7E, 32'h0BADF00D);
    idle(3);
    check_writes("post_rst");
    chk("post_rst_wr_cnt", 64'(wr_cnt), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_cmd_writer.md
ETH_CMD_WRITER -- requirements
Module: eth_cmd_writer

Interface
REQ-001 SHALL have parameter MAX_REC, default 16, meaning the maximum number of write records accepted per packet (1..16).
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 SHALL have port i_rx_data, input, 8, meaning the UDP payload byte.
REQ-005 SHALL have port i_rx_valid, input, 1, meaning i_rx_data is valid this cycle.
REQ-006 SHALL have port i_rx_sop, input, 1, meaning the first payload byte, qualified by i_rx_valid.
REQ-007 SHALL have port i_rx_eop, input, 1, meaning the last payload byte, qualified by i_rx_valid.
REQ-008 SHALL have port o_eb_addr, output, 8, meaning the register-bus write address.
REQ-009 SHALL have port o_eb_wr_data, output, 32, meaning the register-bus write data.
REQ-010 SHALL have port o_eb_wr, output, 1, meaning a single-cycle register-bus write strobe.
REQ-011 SHALL have port o_busy, output, 1, meaning a packet is in progress or a commit is pending.
REQ-012 SHALL have port o_wr_cnt, output, 16, meaning the count of writes issued, wrapping at 0xFFFF->0.
REQ-013 SHALL have port o_err_cnt, output, 8, meaning the count of rejected packets, saturating at 0xFF.

Function
REQ-014 SHALL accept this packet format: byte0 = magic 0xA5; byte1 = N; then N records of 5 bytes each (addr[7:0], data[31:24], [23:16], [15:8], [7:0]); total length is 2+5N bytes.
REQ-015 SHALL implement FSM states IDLE, CNT, ADDR, D0..D3, COMMIT, DROP.
- IDLE -> CNT on sop with byte 0xA5.
- CNT -> ADDR when 1<=N<=MAX_REC.
- ADDR -> D0 -> D1 -> D2 -> D3 -> ADDR, or D3 -> COMMIT/IDLE after the last record.
REQ-016 SHALL treat each of the following as an error (err_cnt+1, then go to DROP, or to IDLE if eop):
- sop with byte != 0xA5;
- N = 0 or N > MAX_REC;
- eop before the final D3 byte;
- last D3 byte without eop.
REQ-017 SHALL, in DROP, discard bytes until eop, then return to IDLE.
REQ-018 SHALL, on a sop in any non-IDLE state, count one error for the abandoned packet and process the sop byte as a new packet start in the same cycle.
REQ-019 SHALL ignore bytes that carry i_rx_valid in IDLE without sop.
REQ-020 SHALL ignore idle cycles (valid=0) without any state change; there is no timeout.
REQ-021 SHALL register o_eb_addr, o_eb_wr_data and o_eb_wr; each write strobe lasts exactly 1 cycle, with address and data held until the next write.
REQ-022 SHALL increment o_wr_cnt in the same cycle o_eb_wr is asserted.
REQ-023 SHALL drive o_busy high in every state other than IDLE.

Reset
REQ-024 SHALL, while rst_n is low, force: FSM=IDLE, o_eb_addr=0, o_eb_wr_data=0, o_eb_wr=0, o_wr_cnt=0, o_err_cnt=0, o_busy=0, record buffer cleared.
REQ-025 SHALL, on reset mid-packet or mid-commit, issue no further writes; the remainder of the packet is ignored until the next sop.

Configuration
REQ-026 SHALL support macro ETH_CMD_ATOMIC_EN.
- Defined: records are stored in a MAX_REC-deep buffer and issued only after a valid final eop. COMMIT issues one write per cycle in record order, starting the cycle after eop. Input bytes are ignored during COMMIT, except that a sop counts as an error and its packet is dropped. An error packet issues no writes.
- Undefined: each record's write is issued 1 cycle after its D3 byte (streaming); records already written stay written if the packet later fails; COMMIT state and buffer are absent.

Structure
REQ-027 SHALL place magic 0xA5, the FSM state encoding and the record width (40) in shared package eth_pkg.
REQ-028 SHALL implement the record buffer as sub-module cmd_rec_buf: write port, sequential read port, clear; instantiated only under ETH_CMD_ATOMIC_EN.

Verification
REQ-029 SHALL cover: packet A5 01 03 11 22 33 44 -> one o_eb_wr, addr=0x03, data=0x11223344, 1 cycle after eop (atomic) or after the D3 byte (streaming); o_wr_cnt=1.
REQ-030 SHALL cover: N=3 packet -> 3 consecutive strobes in record order; o_wr_cnt=3; o_busy low the cycle after the last strobe.
REQ-031 SHALL cover: magic 0x5A, or N=0, or N=17 -> no strobes; o_err_cnt+1; the next valid packet is accepted.
REQ-032 SHALL cover: N=2 packet truncated by eop after record 1 -> atomic: 0 writes; streaming: 1 write; o_err_cnt+1 in both modes.
REQ-033 SHALL cover: sop arriving mid-record -> o_err_cnt+1 and the new packet executes normally; 256 bad packets -> o_err_cnt=0xFF.
REQ-034 SHALL cover: rst_n asserted during COMMIT of N=4 after 2 writes -> all outputs 0 immediately and no further strobes.
